// File: rtl/sipo_frame_ctrl.sv
// Frames a qualified serial bit stream into WIDTH-bit words behind a single-entry
// valid/ready output register. Optional feature macro: PARITY_CHECK_EN (even parity bit).
module sipo_frame_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             din,
    input  logic             din_valid,
    output logic             busy,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic             parity_err
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic [CW-1:0]    cnt;
    logic             can_load;

    always_comb begin
        sreg_next = sreg;
        if (MSB_FIRST) sreg_next = {sreg[WIDTH-2:0], din};
        else           sreg_next = {din, sreg[WIDTH-1:1]};
    end

    // The output slot is free if empty or being drained in this very cycle.
    assign can_load = !dout_valid || dout_ready;
    assign busy     = (state != IDLE);

`ifndef PARITY_CHECK_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
            if (dout_valid && dout_ready) dout_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        cnt <= '0;
                    end else if (din_valid) begin
                        sreg <= sreg_next;
                        cnt  <= cnt + CW'(1);
                        if (cnt == LAST) begin
`ifdef PARITY_CHECK_EN
                            state <= PARITY;
`else
                            state <= IDLE;
                            if (can_load) begin
                                dout       <= sreg_next;
                                dout_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
`endif
                        end
                    end
                end
`ifdef PARITY_CHECK_EN
                PARITY: begin
                    if (start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end else if (din_valid) begin
                        state <= IDLE;
                        if (can_load) begin
                            dout       <= sreg;
                            dout_valid <= 1'b1;
                            parity_err <= ^{sreg, din};
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: directed scenarios plus random traffic, all compared
// every cycle against a queue-based frame model; a few literal values pin the model.
module tb_sipo_frame_ctrl;
    localparam int WIDTH     = 4;
    localparam bit MSB_FIRST = 1'b1;

    logic             clk = 1'b0;
    logic             rst, start, din, din_valid, dout_ready;
    logic             busy, dout_valid, overrun, parity_err;
    logic [WIDTH-1:0] dout;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sipo_frame_ctrl #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
        .busy(busy), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .overrun(overrun), .parity_err(parity_err)
    );

    // Reference model: a frame is the list of bits collected since the last start.
    bit               m_busy, m_valid, m_ovr, m_perr;
    logic [WIDTH-1:0] m_dout;
    bit               bits_q[$];

    function automatic logic [WIDTH-1:0] assemble();
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) w[WIDTH-1-i] = bits_q[i];
            else           w[i]         = bits_q[i];
        end
        return w;
    endfunction

    always @(posedge clk) begin
        bit               done, pe;
        logic [WIDTH-1:0] w;
        if (rst) begin
            m_busy = 0; m_valid = 0; m_ovr = 0; m_perr = 0; m_dout = '0;
            bits_q.delete();
        end else begin
            m_ovr = 0; m_perr = 0; done = 0; pe = 0;
            if (m_valid && dout_ready) m_valid = 0;
            if (start) begin
                m_busy = 1;
                bits_q.delete();
            end else if (m_busy && din_valid) begin
                if (bits_q.size() < WIDTH) begin
                    bits_q.push_back(din);
`ifndef PARITY_CHECK_EN
                    done = (bits_q.size() == WIDTH);
`endif
                end else begin
                    done = 1;
                    pe   = ((($countones(assemble()) + int'(din)) % 2) == 1);
                end
            end
            if (done) begin
                w      = assemble();
                m_busy = 0;
                if (!m_valid) begin
                    m_dout  = w;
                    m_valid = 1;
                    m_perr  = pe;
                end else begin
                    m_ovr = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("dout", 32'(dout), 32'(m_dout));
            chk("dout_valid", 32'(dout_valid), 32'(m_valid));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("parity_err", 32'(parity_err), 32'(m_perr));
        end
    end

    task automatic step(input logic s, input logic d, input logic dv, input logic rdy);
        start = s; din = d; din_valid = dv; dout_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Sends start then the word w (so the received word equals w), optional gaps,
    // and in the parity build an even-parity bit (inverted when bad_par).
    task automatic send_word(input logic [WIDTH-1:0] w, input int max_gap,
                             input logic rdy, input bit bad_par);
        int   g;
        logic b;
        step(1'b1, 1'b0, 1'b0, rdy);
        for (int i = 0; i < WIDTH; i++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 1)) : 0;
            for (int k = 0; k < g; k++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, rdy);
            b = MSB_FIRST ? w[WIDTH-1-i] : w[i];
            step(1'b0, b, 1'b1, rdy);
        end
`ifdef PARITY_CHECK_EN
        step(1'b0, (^w) ^ bad_par, 1'b1, rdy);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_valid", 32'(dout_valid), 32'd0);

        // Basic frame
        send_word(4'b1011, 0, 1'b1, 1'b0);
        chk("basic_dout", 32'(dout), 32'hB);
        chk("basic_valid", 32'(dout_valid), 32'd1);
        chk("basic_busy", 32'(busy), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic_consumed", 32'(dout_valid), 32'd0);

        // Reset mid-frame
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_valid", 32'(dout_valid), 32'd0);
        rst = 1'b0;
        repeat (6) step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        chk("midrst_novalid", 32'(dout_valid), 32'd0);

        // Gapped bits
        send_word(4'b1011, 3, 1'b1, 1'b0);
        chk("gap_dout", 32'(dout), 32'hB);
        chk("gap_valid", 32'(dout_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun
        send_word(4'b1011, 0, 1'b0, 1'b0);
        chk("ovr_first_dout", 32'(dout), 32'hB);
        send_word(4'b0110, 0, 1'b0, 1'b0);
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_kept_dout", 32'(dout), 32'hB);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_one_cycle", 32'(overrun), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_drained", 32'(dout_valid), 32'd0);

        // Restart mid-frame
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        send_word(4'b0110, 0, 1'b1, 1'b0);
        chk("restart_dout", 32'(dout), 32'h6);
        chk("restart_valid", 32'(dout_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef PARITY_CHECK_EN
        send_word(4'b1011, 0, 1'b1, 1'b0);
        chk("par_ok_err", 32'(parity_err), 32'd0);
        chk("par_ok_valid", 32'(dout_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(4'b1011, 0, 1'b1, 1'b1);
        chk("par_bad_err", 32'(parity_err), 32'd1);
        chk("par_bad_dout", 32'(dout), 32'hB);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("par_bad_pulse", 32'(parity_err), 32'd0);
`endif

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0));
        end
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
